// File: rtl/poly_mult_seq.sv
// Sequencer for the sparse poly_mult core: loads position and vector RAMs from two
// streams, kicks the core, waits under a watchdog, then streams the result RAM out.
module poly_mult_seq #(
  parameter int WEIGHT     = 66,
  parameter int LOGW       = 16,
  parameter int LOG_WEIGHT = 7,
  parameter int RAMWIDTH   = 32,
  parameter int VEC_WORDS  = 553,
  parameter int RES_WORDS  = 553,
  parameter int ADDR_WIDTH = 11,
  parameter int TIMEOUT    = 2000000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_start_i,
  input  logic                  cmd_abort_i,
  input  logic                  pos_valid_i,
  output logic                  pos_ready_o,
  input  logic [LOGW-1:0]       pos_data_i,
  input  logic                  vec_valid_i,
  output logic                  vec_ready_o,
  input  logic [RAMWIDTH-1:0]   vec_data_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [RAMWIDTH-1:0]   res_data_o,
  output logic                  res_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_err_o,
  output logic                  pos_wr_en_o,
  output logic [LOG_WEIGHT-1:0] pos_addr_o,
  output logic [LOGW-1:0]       pos_wdata_o,
  output logic                  vec_wr_en_o,
  output logic [ADDR_WIDTH-1:0] vec_addr_o,
  output logic [RAMWIDTH-1:0]   vec_wdata_o,
  output logic                  core_start_o,
  input  logic                  core_valid_i,
  output logic                  core_rd_dout_o,
  output logic [ADDR_WIDTH-1:0] core_addr_result_o,
  input  logic [RAMWIDTH-1:0]   core_dout_i
);

  localparam int CW  = (ADDR_WIDTH > LOG_WEIGHT) ? ADDR_WIDTH : LOG_WEIGHT;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  POS_LAST = CW'(WEIGHT - 1);
  localparam logic [CW-1:0]  VEC_LAST = CW'(VEC_WORDS - 1);
  localparam logic [CW-1:0]  RES_LAST = CW'(RES_WORDS - 1);
  localparam logic [WDW-1:0] WD_LOAD  = WDW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_POS, S_LOAD_VEC, S_START, S_COMPUTE,
    S_RD_ISSUE, S_RD_WAIT, S_RD_HOLD, S_DONE
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_inc;
  logic [WDW-1:0]        wd_q;
  logic                  pos_ready_q, vec_ready_q, res_valid_q, res_last_q;
  logic                  busy_q, done_q, timeout_err_q;
  logic                  pos_wr_en_q, vec_wr_en_q, core_start_q, core_rd_dout_q;
  logic [LOG_WEIGHT-1:0] pos_addr_q;
  logic [LOGW-1:0]       pos_wdata_q;
  logic [ADDR_WIDTH-1:0] vec_addr_q, core_addr_q;
  logic [RAMWIDTH-1:0]   vec_wdata_q, res_data_q;

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      wd_q           <= '0;
      pos_ready_q    <= 1'b0;
      vec_ready_q    <= 1'b0;
      res_valid_q    <= 1'b0;
      res_last_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      pos_wr_en_q    <= 1'b0;
      vec_wr_en_q    <= 1'b0;
      core_start_q   <= 1'b0;
      core_rd_dout_q <= 1'b0;
      pos_addr_q     <= '0;
      pos_wdata_q    <= '0;
      vec_addr_q     <= '0;
      vec_wdata_q    <= '0;
      core_addr_q    <= '0;
      res_data_q     <= '0;
    end else begin
      pos_wr_en_q    <= 1'b0;
      vec_wr_en_q    <= 1'b0;
      core_start_q   <= 1'b0;
      core_rd_dout_q <= 1'b0;
      done_q         <= 1'b0;
      if (cmd_abort_i) begin
        // a beat handshaking in the abort cycle is dropped, not written
        state_q     <= S_IDLE;
        pos_ready_q <= 1'b0;
        vec_ready_q <= 1'b0;
        res_valid_q <= 1'b0;
        res_last_q  <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (cmd_start_i) begin
            state_q       <= S_LOAD_POS;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b1;
            pos_ready_q   <= 1'b1;
          end
          S_LOAD_POS: if (pos_valid_i && pos_ready_q) begin
            pos_wr_en_q <= 1'b1;
            pos_addr_q  <= cnt_q[LOG_WEIGHT-1:0];
            pos_wdata_q <= pos_data_i;
            if (cnt_q == POS_LAST) begin
              cnt_q       <= '0;
              pos_ready_q <= 1'b0;
              vec_ready_q <= 1'b1;
              state_q     <= S_LOAD_VEC;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          S_LOAD_VEC: if (vec_valid_i && vec_ready_q) begin
            vec_wr_en_q <= 1'b1;
            vec_addr_q  <= cnt_q[ADDR_WIDTH-1:0];
            vec_wdata_q <= vec_data_i;
            if (cnt_q == VEC_LAST) begin
              cnt_q       <= '0;
              vec_ready_q <= 1'b0;
              state_q     <= S_START;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          S_START: begin
            core_start_q <= 1'b1;
            wd_q         <= WD_LOAD;
            state_q      <= S_COMPUTE;
          end
          S_COMPUTE: begin
            if (core_valid_i) begin
              cnt_q          <= '0;
              core_rd_dout_q <= 1'b1;
              core_addr_q    <= '0;
              state_q        <= S_RD_ISSUE;
            end else if (wd_q == '0) begin
              timeout_err_q <= 1'b1;
              busy_q        <= 1'b0;
              state_q       <= S_IDLE;
            end else begin
              wd_q <= wd_q - 1'b1;
            end
          end
          S_RD_ISSUE: state_q <= S_RD_WAIT;
          S_RD_WAIT: begin
            res_data_q  <= core_dout_i;
            res_valid_q <= 1'b1;
            res_last_q  <= (cnt_q == RES_LAST);
            state_q     <= S_RD_HOLD;
          end
          S_RD_HOLD: if (res_ready_i) begin
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            if (cnt_q == RES_LAST) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cnt_q          <= cnt_inc;
              core_addr_q    <= cnt_inc[ADDR_WIDTH-1:0];
              core_rd_dout_q <= 1'b1;
              state_q        <= S_RD_ISSUE;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign pos_ready_o        = pos_ready_q;
  assign vec_ready_o        = vec_ready_q;
  assign res_valid_o        = res_valid_q;
  assign res_data_o         = res_data_q;
  assign res_last_o         = res_last_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign timeout_err_o      = timeout_err_q;
  assign pos_wr_en_o        = pos_wr_en_q;
  assign pos_addr_o         = pos_addr_q;
  assign pos_wdata_o        = pos_wdata_q;
  assign vec_wr_en_o        = vec_wr_en_q;
  assign vec_addr_o         = vec_addr_q;
  assign vec_wdata_o        = vec_wdata_q;
  assign core_start_o       = core_start_q;
  assign core_rd_dout_o     = core_rd_dout_q;
  assign core_addr_result_o = core_addr_q;

endmodule

// File: tb/tb_poly_mult_seq.sv
// Bench for poly_mult_seq: transaction scoreboard on the main instance plus a second
// instance with a short watchdog and a core that never answers.
module tb_poly_mult_seq;

  logic        clk = 1'b0;
  logic        rst, cmd_start, cmd_abort, pos_valid, vec_valid, res_ready;
  logic [15:0] pos_data;
  logic [31:0] vec_data;
  logic        core_valid;
  logic [31:0] core_dout;

  logic        pos_ready, vec_ready, res_valid, res_last, busy, done, timeout_err;
  logic        pos_wr_en, vec_wr_en, core_start, core_rd_dout;
  logic [31:0] res_data, vec_wdata;
  logic [15:0] pos_wdata;
  logic [6:0]  pos_addr;
  logic [10:0] vec_addr, core_addr;

  logic        t_pos_ready, t_vec_ready, t_res_valid, t_res_last, t_busy, t_done, t_timeout_err;
  logic        t_pos_wr_en, t_vec_wr_en, t_core_start, t_core_rd_dout;
  logic [31:0] t_res_data, t_vec_wdata;
  logic [15:0] t_pos_wdata;
  logic [6:0]  t_pos_addr;
  logic [10:0] t_vec_addr, t_core_addr;

  always #5 clk = ~clk;

  // main instance: watchdog long enough for the 100-cycle core latency
  poly_mult_seq #(.TIMEOUT(200)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_start_i(cmd_start), .cmd_abort_i(cmd_abort),
    .pos_valid_i(pos_valid), .pos_ready_o(pos_ready), .pos_data_i(pos_data),
    .vec_valid_i(vec_valid), .vec_ready_o(vec_ready), .vec_data_i(vec_data),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data), .res_last_o(res_last),
    .busy_o(busy), .done_o(done), .timeout_err_o(timeout_err),
    .pos_wr_en_o(pos_wr_en), .pos_addr_o(pos_addr), .pos_wdata_o(pos_wdata),
    .vec_wr_en_o(vec_wr_en), .vec_addr_o(vec_addr), .vec_wdata_o(vec_wdata),
    .core_start_o(core_start), .core_valid_i(core_valid), .core_rd_dout_o(core_rd_dout),
    .core_addr_result_o(core_addr), .core_dout_i(core_dout));

  poly_mult_seq #(.TIMEOUT(50)) dut_to (
    .clk_i(clk), .rst_i(rst), .cmd_start_i(cmd_start), .cmd_abort_i(cmd_abort),
    .pos_valid_i(pos_valid), .pos_ready_o(t_pos_ready), .pos_data_i(pos_data),
    .vec_valid_i(vec_valid), .vec_ready_o(t_vec_ready), .vec_data_i(vec_data),
    .res_valid_o(t_res_valid), .res_ready_i(res_ready), .res_data_o(t_res_data), .res_last_o(t_res_last),
    .busy_o(t_busy), .done_o(t_done), .timeout_err_o(t_timeout_err),
    .pos_wr_en_o(t_pos_wr_en), .pos_addr_o(t_pos_addr), .pos_wdata_o(t_pos_wdata),
    .vec_wr_en_o(t_vec_wr_en), .vec_addr_o(t_vec_addr), .vec_wdata_o(t_vec_wdata),
    .core_start_o(t_core_start), .core_valid_i(1'b0), .core_rd_dout_o(t_core_rd_dout),
    .core_addr_result_o(t_core_addr), .core_dout_i(32'h0));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] res_word(input logic [10:0] a);
    return {16'hC0DE, 5'b0, a};
  endfunction

  function automatic logic [15:0] pos_word(input int i);
    return 16'(i);
  endfunction

  function automatic logic [31:0] vec_word(input int i);
    return 32'hA5A5_0000 + 32'(i);
  endfunction

  // core model: valid ~100 cycles after start, read data one cycle after address
  int cv_cnt;
  bit cv_arm;
  always @(posedge clk) begin
    if (rst || cmd_abort || cmd_start) begin
      core_valid <= 1'b0;
      cv_arm     <= 1'b0;
      cv_cnt     <= 0;
    end else if (core_start) begin
      cv_arm <= 1'b1;
      cv_cnt <= 1;
    end else if (cv_arm) begin
      if (cv_cnt == 100) core_valid <= 1'b1;
      else cv_cnt <= cv_cnt + 1;
    end
    if (core_rd_dout) core_dout <= res_word(core_addr);
    else if (rst) core_dout <= 32'h0;
  end

  // scoreboard state, owned by the compare process
  int op_id = 0;
  int seen_op = 0;
  int pos_n, vec_n, cs_n, res_idx, to_k;
  bit hold_prev, last_hs_prev, to_arm, to_fired, hs;
  logic [31:0] data_prev;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 0; last_hs_prev = 0; to_arm = 0; to_fired = 0;
    end else begin
      if (op_id != seen_op) begin
        seen_op = op_id;
        pos_n = 0; vec_n = 0; cs_n = 0; res_idx = 0;
        hold_prev = 0; last_hs_prev = 0; to_arm = 0; to_fired = 0;
      end
      if (pos_wr_en) begin
        if (pos_n < 66) begin
          check("pos_addr", pos_addr, pos_n);
          check("pos_wdata", pos_wdata, pos_word(pos_n));
          if (pos_n == 65) check("pos_wdata_lit65", pos_wdata, 16'h0041);
        end else check("pos_extra_write", pos_n, 65);
        pos_n++;
      end
      if (vec_wr_en) begin
        if (vec_n < 553) begin
          check("vec_addr", vec_addr, vec_n);
          check("vec_wdata", vec_wdata, vec_word(vec_n));
          if (vec_n == 552) check("vec_wdata_lit552", vec_wdata, 32'hA5A5_0228);
        end else check("vec_extra_write", vec_n, 552);
        vec_n++;
      end
      if (core_start) begin
        check("core_start_after_vec", vec_n, 553);
        check("core_start_no_wr", vec_wr_en, 1'b0);
        cs_n++;
      end
      if (core_rd_dout) check("rd_addr", core_addr, res_idx);
      if (hold_prev) begin
        check("res_valid_held", res_valid, 1'b1);
        check("res_data_held", res_data, data_prev);
      end
      check("done_timing", done, last_hs_prev);
      hs = res_valid && res_ready;
      last_hs_prev = 0;
      if (hs) begin
        check("res_data", res_data, res_word(res_idx[10:0]));
        check("res_last", res_last, res_idx == 552);
        if (res_idx == 0) check("res_lit0", res_data, 32'hC0DE_0000);
        if (res_idx == 552) check("res_lit552", res_data, 32'hC0DE_0228);
        last_hs_prev = (res_idx == 552);
        res_idx++;
      end
      hold_prev = res_valid && !res_ready;
      data_prev = res_data;
      if (t_core_start) begin
        to_k = 0; to_arm = 1;
      end else if (to_arm) begin
        to_k++;
        if (to_k == 49) check("to_before_expiry", t_timeout_err, 1'b0);
        if (to_k == 50) begin
          check("to_expiry", t_timeout_err, 1'b1);
          check("to_idle", t_busy, 1'b0);
          to_arm = 0;
          to_fired = 1;
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_pos_ready"}, pos_ready, 0);
    check({tag, "_vec_ready"}, vec_ready, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_last"}, res_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_pos_wr_en"}, pos_wr_en, 0);
    check({tag, "_pos_addr"}, pos_addr, 0);
    check({tag, "_pos_wdata"}, pos_wdata, 0);
    check({tag, "_vec_wr_en"}, vec_wr_en, 0);
    check({tag, "_vec_addr"}, vec_addr, 0);
    check({tag, "_vec_wdata"}, vec_wdata, 0);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_core_rd_dout"}, core_rd_dout, 0);
    check({tag, "_core_addr"}, core_addr, 0);
  endtask

  task automatic begin_op();
    check("idle_busy", busy, 1'b0);
    if (to_fired) check("to_sticky", t_timeout_err, 1'b1);
    op_id++;
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_pos_ready", pos_ready, 1'b1);
    check("to_cleared", t_timeout_err, 1'b0);
  endtask

  task automatic send_pos(input bit gaps, output int cyc);
    bit acc;
    int c;
    cyc = 0;
    for (int i = 0; i < 66; i++) begin
      if (gaps) begin
        pos_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (gaps && i == 30) cmd_start = 1'b1;
      pos_data = pos_word(i);
      pos_valid = 1'b1;
      acc = 0; c = 0;
      while (!acc && c < 200) begin
        @(negedge clk); acc = pos_ready;
        @(posedge clk); #1; c++;
        cmd_start = 1'b0;
      end
      check("pos_handshake", acc, 1'b1);
      cyc += c;
    end
    pos_valid = 1'b0;
  endtask

  task automatic send_vec(input int abort_at, output bit aborted, output int cyc);
    bit acc;
    int c;
    aborted = 0; cyc = 0;
    for (int i = 0; i < 553 && !aborted; i++) begin
      vec_data = vec_word(i);
      vec_valid = 1'b1;
      if (i == abort_at) begin
        cmd_abort = 1'b1;
        @(posedge clk); #1;
        cmd_abort = 1'b0;
        vec_valid = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_vec_ready", vec_ready, 1'b0);
        check("abort_vec_wr_en", vec_wr_en, 1'b0);
        aborted = 1;
      end else begin
        acc = 0; c = 0;
        while (!acc && c < 200) begin
          @(negedge clk); acc = vec_ready;
          @(posedge clk); #1; c++;
        end
        check("vec_handshake", acc, 1'b1);
        cyc += c;
      end
    end
    vec_valid = 1'b0;
  endtask

  task automatic recv_all(input int stall_at);
    bit got, stalled;
    int t;
    got = 0; stalled = 0; t = 0;
    res_ready = 1'b1;
    while (!got && t < 6000) begin
      @(posedge clk); #1; t++;
      got = done;
      if (!got && !stalled && stall_at >= 0 && res_idx == stall_at && res_valid) begin
        res_ready = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        res_ready = 1'b1;
        stalled = 1;
      end
    end
    check("done_seen", got, 1'b1);
    if (stall_at >= 0) check("stall_applied", stalled, 1'b1);
    @(posedge clk); #1;
    check("end_busy", busy, 1'b0);
    check("end_done_low", done, 1'b0);
  endtask

  task automatic run_op(input bit gaps, input int stall_at, input int abort_at);
    int cyc_pos, cyc_vec;
    bit aborted;
    begin_op();
    send_pos(gaps, cyc_pos);
    if (!gaps) check("pos_throughput", cyc_pos, 66);
    send_vec(abort_at, aborted, cyc_vec);
    if (aborted) begin
      repeat (150) @(posedge clk); #1;
      check("abort_no_core_start", cs_n, 0);
      check("abort_vec_count", vec_n, abort_at);
      check("abort_idle", busy, 1'b0);
    end else begin
      check("vec_throughput", cyc_vec, 553);
      recv_all(stall_at);
      check("pos_count", pos_n, 66);
      check("vec_count", vec_n, 553);
      check("core_start_count", cs_n, 1);
      check("res_count", res_idx, 553);
      check("main_no_timeout", timeout_err, 1'b0);
    end
  endtask

  task automatic reset_in_hold();
    int c, t;
    bit a;
    begin_op();
    send_pos(1'b0, c);
    send_vec(-1, a, c);
    res_ready = 1'b0;
    t = 0;
    while (!res_valid && t < 1000) begin @(posedge clk); #1; t++; end
    check("hold_reached", res_valid, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    check("hold_still_valid", res_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("rst_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", busy, 1'b0);
    check("post_rst_pos_ready", pos_ready, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0;
    pos_valid = 1'b0; vec_valid = 1'b0; res_ready = 1'b0;
    pos_data = '0; vec_data = '0;
    repeat (3) @(posedge clk); #1;
    check_all_zero("rst");
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_rst", busy, 1'b0);

    run_op(1'b0, -1, -1);
    run_op(1'b1, 300, -1);
    run_op(1'b0, -1, 200);

    cmd_start = 1'b1; cmd_abort = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0; cmd_abort = 1'b0;
    check("abort_beats_start_busy", busy, 1'b0);
    check("abort_beats_start_ready", pos_ready, 1'b0);

    run_op(1'b0, -1, -1);
    reset_in_hold();
    run_op(1'b0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/poly_mult_seq.md
Name: poly_mult_seq

Overview:
- Sequencer placed in front of the sparse poly_mult core and its two operand RAMs (position RAM, random-bits RAM); replaces ad-hoc key/data host poking.
- Accepts a start command, then streams in WEIGHT shift positions and VEC_WORDS random-vector words over valid/ready.
- Pulses core start, waits for core valid under a watchdog, then streams RES_WORDS result words out over valid/ready, with last-flag framing.

Parameters:
- WEIGHT, 66: number of shift positions loaded per operation.
- LOGW, 16: width of one position entry.
- LOG_WEIGHT, 7: position RAM address width.
- RAMWIDTH, 32: vector/result word width.
- VEC_WORDS, 553: random-vector words loaded.
- RES_WORDS, 553: result words read out.
- ADDR_WIDTH, 11: vector RAM and result address width.
- TIMEOUT, 2000000: maximum cycles allowed in COMPUTE.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- cmd_start  in  1  begin operation; sampled only in IDLE.
- cmd_abort  in  1  return to IDLE from any state next cycle.
- pos_valid/pos_ready  in/out  1/1  position stream handshake.
- pos_data  in  LOGW  shift position.
- vec_valid/vec_ready  in/out  1/1  vector stream handshake.
- vec_data  in  RAMWIDTH  random-bits word.
- res_valid/res_ready  out/in  1/1  result stream handshake.
- res_data  out  RAMWIDTH  result word.
- res_last  out  1  high with the final result word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result handshake.
- timeout_err  out  1  sticky; set on watchdog expiry, cleared by cmd_start or rst.
- pos_wr_en  out  1  position RAM write enable.
- pos_addr  out  LOG_WEIGHT  position RAM write address.
- pos_wdata  out  LOGW  position RAM write data.
- vec_wr_en  out  1  vector RAM write enable.
- vec_addr  out  ADDR_WIDTH  vector RAM write address.
- vec_wdata  out  RAMWIDTH  vector RAM write data.
- core_start  out  1  one-cycle start pulse to core.
- core_valid  in  1  core result ready (level).
- core_rd_dout  out  1  core result-read enable.
- core_addr_result  out  ADDR_WIDTH  result read address.
- core_dout  in  RAMWIDTH  result data, valid 1 cycle after address with core_rd_dout high.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-operation abandons everything; no partial outputs persist.
- IDLE: cmd_start=1 -> LOAD_POS, counter 0, timeout_err cleared.
- LOAD_POS: pos_ready=1. Each pos handshake registers pos_wr_en=1, pos_addr=count, pos_wdata=pos_data the next cycle. On handshake with count=WEIGHT-1 -> LOAD_VEC. pos_ready=0 in all other states.
- LOAD_VEC: same scheme with vec_*. On handshake with count=VEC_WORDS-1 -> START. Write strobes are single-cycle registered outputs; no gaps are required between beats, so throughput is 1 beat per cycle.
- START: core_start=1 for exactly one cycle; the last RAM write has already landed. -> COMPUTE; watchdog cleared.
- COMPUTE: watchdog increments each cycle. core_valid=1 -> RD_ISSUE, counter 0. If the watchdog reaches TIMEOUT-1 with no valid, set timeout_err and go -> IDLE. core_valid in the same cycle as expiry wins.
- RD_ISSUE: core_rd_dout=1, core_addr_result=counter -> RD_WAIT.
- RD_WAIT: capture core_dout into res_data; res_valid=1 next cycle -> RD_HOLD.
- RD_HOLD: res_valid and res_data stay stable until res_ready. res_last=(counter==RES_WORDS-1). On handshake:
  - last word -> DONE;
  - otherwise counter+1 -> RD_ISSUE.
  - Throughput is at most 1 word per 3 cycles.
- DONE: done=1 for one cycle -> IDLE.
- cmd_abort has priority over every transition, including a simultaneous cmd_start. It deasserts all strobes, ready and valid signals next cycle. A write strobe already registered completes; no core_start is issued after an abort.
- cmd_start outside IDLE is ignored.
- All counters are sized to hold their maximum; no wrap within an operation.

Test Plan:
- Nominal: cmd_start; 66 positions 0..65, then 553 vector words 0xA5A50000+i; core model asserts valid 100 cycles after start -> pos writes at addr 0..65 with matching data, vec writes at addr 0..552. Exactly one core_start, issued after the last write. 553 results read at addr 0..552, res_last on word 552, done pulse, busy low.
- Input gaps: pos_valid toggles every other cycle -> all 66 writes correct, no duplicates, no missed addresses.
- Result backpressure: res_ready low for 10 cycles mid-stream -> res_data stable throughout, no address skipped, word order preserved.
- Timeout with TIMEOUT=50, core_valid never asserted -> timeout_err=1 at cycle 50 after start, return to IDLE; next cmd_start clears timeout_err.
- Abort during LOAD_VEC at word 200 -> IDLE next cycle, busy=0, no core_start; a fresh full operation then completes correctly.
- Reset during RD_HOLD -> all outputs 0 next cycle, state IDLE.
